// File: rtl/mem_port_arbiter_if.sv
// Request/response bus shared by the fetch port, the data port and the memory side.
// On the memory side "done" is the memory's accept/complete acknowledge.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic          sb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          done;

    modport master (
        output req, we, sb, addr, wdata,
        input  rdata, done
    );

    modport slave (
        input  req, we, sb, addr, wdata,
        output rdata, done
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Default: data priority with a fetch starvation guard; define ARB_RR_EN for round-robin ties.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   if_port,
    mem_port_arbiter_if.slave   d_port,
    mem_port_arbiter_if.master  m_port,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          grant_i, grant_d, pick_i;
    logic          owner_i_reg;
    logic          m_we_reg, m_sb_reg;
    logic [AW-1:0] m_addr_reg;
    logic [DW-1:0] m_wdata_reg;
    logic [DW-1:0] if_rdata_reg, d_rdata_reg;

`ifdef ARB_RR_EN
    // Set when fetch should win the next tie.
    logic rr_fetch_reg;

    assign pick_i = if_port.req & (~d_port.req | rr_fetch_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_fetch_reg <= 1'b0;
        end else if (grant_i) begin
            rr_fetch_reg <= 1'b0;
        end else if (grant_d) begin
            rr_fetch_reg <= 1'b1;
        end
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_reg;
    logic          starved;

    assign starved = (starve_reg == SW'(STARVE_MAX));
    assign pick_i  = if_port.req & (~d_port.req | starved);

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_reg <= '0;
        end else if (grant_i) begin
            starve_reg <= '0;
        end else if (state_reg == IDLE && !if_port.req) begin
            starve_reg <= '0;
        end else if (grant_d && !starved) begin
            starve_reg <= starve_reg + SW'(1);
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_i) begin
                    grant_i    = 1'b1;
                    state_next = GNT_I;
                end else if (d_port.req) begin
                    grant_d    = 1'b1;
                    state_next = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (m_port.done) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Memory command is latched once at grant so it stays stable while waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_i_reg  <= 1'b0;
            m_we_reg     <= 1'b0;
            m_sb_reg     <= 1'b0;
            m_addr_reg   <= '0;
            m_wdata_reg  <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if (grant_i) begin
                owner_i_reg <= 1'b1;
                m_we_reg    <= 1'b0;
                m_sb_reg    <= 1'b0;
                m_addr_reg  <= if_port.addr;
                m_wdata_reg <= '0;
            end else if (grant_d) begin
                owner_i_reg <= 1'b0;
                m_we_reg    <= d_port.we;
                m_sb_reg    <= d_port.sb;
                m_addr_reg  <= d_port.addr;
                m_wdata_reg <= d_port.wdata;
            end
            if (state_reg == GNT_I && m_port.done) begin
                if_rdata_reg <= m_port.rdata;
            end
            if (state_reg == GNT_D && m_port.done && !m_we_reg) begin
                d_rdata_reg <= m_port.rdata;
            end
        end
    end

    assign m_port.req   = (state_reg == GNT_I) || (state_reg == GNT_D);
    assign m_port.we    = m_we_reg;
    assign m_port.sb    = m_sb_reg;
    assign m_port.addr  = m_addr_reg;
    assign m_port.wdata = m_wdata_reg;

    assign if_port.rdata = if_rdata_reg;
    assign if_port.done  = (state_reg == RESP) && owner_i_reg;
    assign d_port.rdata  = d_rdata_reg;
    assign d_port.done   = (state_reg == RESP) && !owner_i_reg;

    assign busy = (state_reg != IDLE);

endmodule
